// File: rtl/full_subtractor_pkg.sv
// Shared constants and the borrow equation for the registered full subtractor.
package full_subtractor_pkg;

   localparam int FS_MAX_WIDTH = 64;

   // Borrow out of one bit position: a borrow is generated when b > a,
   // and an incoming borrow propagates when a == b.
   function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
      return (~a & b) | (~(a ^ b) & bin);
   endfunction

endpackage

// File: rtl/full_subtractor_pipe_if.sv
// Operand/result bundle for full_subtractor_pipe.
// Optional macro FS_SIGNED_OVF_EN adds the registered signed-overflow flag ovf.
interface full_subtractor_pipe_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             out_valid;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef FS_SIGNED_OVF_EN
   logic             ovf;

   modport master (output in_valid, A, B, Bin, input out_valid, Diff, Bout, ovf);
   modport slave  (input in_valid, A, B, Bin, output out_valid, Diff, Bout, ovf);
`else
   modport master (output in_valid, A, B, Bin, input out_valid, Diff, Bout);
   modport slave  (input in_valid, A, B, Bin, output out_valid, Diff, Bout);
`endif
endinterface

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor_cell
   import full_subtractor_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/full_subtractor_pipe.sv
// Registered WIDTH-bit full subtractor: Diff = (A - B - Bin) mod 2^WIDTH,
// Bout = borrow out, one cycle of latency, always ready.
// Optional macro FS_SIGNED_OVF_EN registers a two's-complement overflow flag (ovf).
module full_subtractor_pipe
   import full_subtractor_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   full_subtractor_pipe_if.slave bus
);

   if (WIDTH < 1 || WIDTH > FS_MAX_WIDTH) begin : g_width_check
      $error("full_subtractor_pipe: WIDTH out of range 1..64");
   end

   logic [WIDTH:0]   bw;
   logic [WIDTH-1:0] diff_c;

   assign bw[0] = bus.Bin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_subtractor_cell u_cell (
         .a    (bus.A[i]),
         .b    (bus.B[i]),
         .bin  (bw[i]),
         .d    (diff_c[i]),
         .bout (bw[i+1])
      );
   end

`ifdef FS_SIGNED_OVF_EN
   logic ovf_c;

   // Overflow only when operand signs differ and the result sign leaves A's sign.
   always_comb begin
      ovf_c = 1'b0;
      if ((bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1])) begin
         ovf_c = 1'b1;
      end
   end

   // Overflow flag captured with the result; holds while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.ovf <= 1'b0;
      end else if (bus.in_valid) begin
         bus.ovf <= ovf_c;
      end
   end
`endif

   // Result register: load on in_valid, hold otherwise; reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.Diff      <= '0;
         bus.Bout      <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.Diff <= diff_c;
            bus.Bout <= bw[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_full_subtractor_pipe.sv
// Bench for full_subtractor_pipe: a WIDTH=1 and a WIDTH=8 instance on one clock/reset.
module tb_full_subtractor_pipe;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   full_subtractor_pipe_if #(.WIDTH(1)) if1 ();
   full_subtractor_pipe_if #(.WIDTH(8)) if8 ();

   full_subtractor_pipe #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   full_subtractor_pipe #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: borrow and difference straight from unsigned arithmetic.
   function automatic logic [8:0] ref_sub8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int r;
      r = int'(a) - int'(b) - int'(bin);
      return (r < 0) ? 9'(r + 512) : 9'(r);
   endfunction

   function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int r;
      r = int'($signed(a)) - int'($signed(b)) - int'(bin);
      return (r < -128) || (r > 127);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
      if8.in_valid = v;
      if8.A        = a;
      if8.B        = b;
      if8.Bin      = bin;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if1.in_valid = 1'b1; if1.A = 1'b1; if1.B = 1'b0; if1.Bin = 1'b0;
      drive8(1'b1, 8'h01, 8'h00, 1'b0);
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (if8.out_valid !== 1'b0 || if8.Diff !== 8'h00 || if8.Bout !== 1'b0) begin
            failures++;
            $display("FAIL reset8 cyc%0d got v=%b d=%h b=%b exp v=0 d=00 b=0", c, if8.out_valid, if8.Diff, if8.Bout);
         end
         checks++;
         if (if1.out_valid !== 1'b0 || if1.Diff !== 1'b0 || if1.Bout !== 1'b0) begin
            failures++;
            $display("FAIL reset1 cyc%0d got v=%b d=%b b=%b exp v=0 d=0 b=0", c, if1.out_valid, if1.Diff, if1.Bout);
         end
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (if8.out_valid !== 1'b1 || if8.Diff !== 8'h01 || if8.Bout !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got v=%b d=%h b=%b exp v=1 d=01 b=0", if8.out_valid, if8.Diff, if8.Bout);
      end
      if1.in_valid = 1'b0;
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      step();
   endtask

   task automatic test_truth_table();
      logic [7:0] exp_d;
      logic [7:0] exp_b;
      logic [2:0] idx;
      exp_d = 8'b1001_0110;
      exp_b = 8'b1000_1110;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         if1.in_valid = 1'b1;
         if1.A   = idx[2];
         if1.B   = idx[1];
         if1.Bin = idx[0];
         step();
         checks++;
         if (if1.out_valid !== 1'b1 || if1.Diff !== exp_d[i] || if1.Bout !== exp_b[i]) begin
            failures++;
            $display("FAIL truth_%0d%0d%0d got v=%b d=%b b=%b exp v=1 d=%b b=%b",
                     idx[2], idx[1], idx[0], if1.out_valid, if1.Diff, if1.Bout, exp_d[i], exp_b[i]);
         end
      end
      if1.in_valid = 1'b0;
      step();
   endtask

   task automatic test_boundary();
      drive8(1'b1, 8'h00, 8'h00, 1'b1);
      step();
      checks++;
      if (if8.Diff !== 8'hFF || if8.Bout !== 1'b1 || if8.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL wrap got v=%b d=%h b=%b exp v=1 d=ff b=1", if8.out_valid, if8.Diff, if8.Bout);
      end
      drive8(1'b1, 8'h5A, 8'h5A, 1'b0);
      step();
      checks++;
      if (if8.Diff !== 8'h00 || if8.Bout !== 1'b0 || if8.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL equal got v=%b d=%h b=%b exp v=1 d=00 b=0", if8.out_valid, if8.Diff, if8.Bout);
      end
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      logic       bin;
      logic [8:0] exp;
      int         bad;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         bin = 1'($urandom);
         drive8(1'b1, a, b, bin);
         exp = ref_sub8(a, b, bin);
         step();
         checks++;
         if (if8.out_valid !== 1'b1 || {if8.Bout, if8.Diff} !== exp) begin
            failures++;
            if (bad < 10)
               $display("FAIL b2b_%0d a=%h b=%h bin=%b got v=%b {b,d}=%h exp v=1 {b,d}=%h",
                        n, a, b, bin, if8.out_valid, {if8.Bout, if8.Diff}, exp);
            bad++;
         end
`ifdef FS_SIGNED_OVF_EN
         checks++;
         if (if8.ovf !== ref_ovf8(a, b, bin)) begin
            failures++;
            if (bad < 10)
               $display("FAIL b2b_ovf_%0d a=%h b=%h bin=%b got %b exp %b", n, a, b, bin, if8.ovf, ref_ovf8(a, b, bin));
            bad++;
         end
`endif
      end
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      step();
   endtask

   task automatic test_hold();
      drive8(1'b1, 8'h50, 8'h14, 1'b0);
      step();
      checks++;
      if (if8.Diff !== 8'h3C || if8.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL hold_load got v=%b d=%h exp v=1 d=3c", if8.out_valid, if8.Diff);
      end
      if8.in_valid = 1'b0;
      if8.A        = 'x;
      if8.B        = 'x;
      if8.Bin      = 1'bx;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (if8.out_valid !== 1'b0 || if8.Diff !== 8'h3C || if8.Bout !== 1'b0) begin
            failures++;
            $display("FAIL hold_cyc%0d got v=%b d=%h b=%b exp v=0 d=3c b=0", c, if8.out_valid, if8.Diff, if8.Bout);
         end
      end
      drive8(1'b1, 8'h01, 8'h02, 1'b0);
      step();
      checks++;
      if (if8.Diff !== 8'hFF || if8.Bout !== 1'b1) begin
         failures++;
         $display("FAIL pre_pulse got d=%h b=%b exp d=ff b=1", if8.Diff, if8.Bout);
      end
      drive8(1'b1, 8'h33, 8'h44, 1'b1);
      rst_n = 1'b0;
      step();
      checks++;
      if (if8.out_valid !== 1'b0 || if8.Diff !== 8'h00 || if8.Bout !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got v=%b d=%h b=%b exp v=0 d=00 b=0", if8.out_valid, if8.Diff, if8.Bout);
      end
      rst_n = 1'b1;
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      step();
   endtask

`ifdef FS_SIGNED_OVF_EN
   task automatic test_ovf();
      drive8(1'b1, 8'h80, 8'h01, 1'b0);
      step();
      checks++;
      if (if8.Diff !== 8'h7F || if8.ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got d=%h ovf=%b exp d=7f ovf=1", if8.Diff, if8.ovf);
      end
      drive8(1'b1, 8'h10, 8'h01, 1'b0);
      step();
      checks++;
      if (if8.Diff !== 8'h0F || if8.ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr got d=%h ovf=%b exp d=0f ovf=0", if8.Diff, if8.ovf);
      end
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      step();
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      if1.in_valid = 1'b0; if1.A = 1'b0; if1.B = 1'b0; if1.Bin = 1'b0;
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      test_reset();
      test_truth_table();
      test_boundary();
      test_back_to_back();
      test_hold();
`ifdef FS_SIGNED_OVF_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
